// File: rtl/gray_count_decoder.sv
// gray_count_decoder: synchronises a Gray count, decodes it to binary and checks each sampled step for +1 progression.
// Define GRAY_DEC_SYNC_EN to insert the two-flop synchroniser for asynchronous gray_in sources.
module gray_count_decoder #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             sample_en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);
  typedef enum logic {IDLE, TRACK} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] g, b, inc, bin_n;
  logic [ERR_W-1:0] cnt_n;
  logic valid_n, up_n, err_n, track;
`ifdef GRAY_DEC_SYNC_EN
  logic [WIDTH-1:0] sync1;
  always_ff @(posedge clk or posedge rst)
    if (rst) {g, sync1} <= '0;
    else {g, sync1} <= {sync1, gray_in};
`else
  assign g = gray_in;
`endif
  // each binary bit is the parity of all Gray bits at or above it
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    assign b[i] = ^g[WIDTH-1:i];
  end
  always_comb begin
    inc = bin_out + WIDTH'(1);
    track = state == TRACK;
    state_n = sample_en ? TRACK : state;
    bin_n = sample_en ? b : bin_out;
    valid_n = sample_en | bin_valid;
    up_n = sample_en & track & (b == inc);
    err_n = sample_en & track & (b != bin_out) & (b != inc);
    cnt_n = clr_err ? '0 : (err_n && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bin_out <= '0;
      bin_valid <= 1'b0;
      step_up <= 1'b0;
      step_err <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      bin_out <= bin_n;
      bin_valid <= valid_n;
      step_up <= up_n;
      step_err <= err_n;
      err_count <= cnt_n;
    end
endmodule

// File: doc/gray_count_decoder.md
Name: gray_count_decoder

Overview:
- Receive-side companion to the 3-bit Gray up-counter.
- Takes a Gray-coded count bus that may come from another clock domain, synchronises it, and decodes it back to binary.
- Checks every sampled step for legal +1 Gray progression, including wrap-around.
- Sits between any Gray-counter source and downstream logic that needs the binary count plus an integrity indication.

Parameters:
WIDTH, 3, width of the Gray input and the binary output
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
gray_in  input  WIDTH  Gray-coded count from the source; may be asynchronous to clk
sample_en  input  1  when high at a clk edge, the synchronised value is decoded and checked
clr_err  input  1  synchronous clear of err_count
bin_out  output  WIDTH  last decoded binary value (registered)
bin_valid  output  1  high once at least one sample has been taken since reset
step_up  output  1  one-cycle pulse: the last sample was exactly previous+1 mod 2^WIDTH
step_err  output  1  one-cycle pulse: the last sample was neither equal to previous nor previous+1
err_count  output  ERR_W  saturating count of step_err events

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is asynchronous and active-high, as already decided.
  - On rst, all outputs are 0: bin_out, bin_valid, step_up, step_err and err_count.
  - On rst, the synchroniser flops are 0 and the FSM goes to IDLE.
- Synchroniser: two-flop chain on gray_in, clocked every cycle regardless of sample_en.
- Decode (combinational, on the synchroniser output g):
  - b[WIDTH-1] = g[WIDTH-1].
  - b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0.
- FSM with two states, IDLE and TRACK:
  - IDLE, sample_en=1: bin_out<=b, bin_valid<=1, go to TRACK. No step_up or step_err.
  - IDLE, sample_en=0: hold.
  - TRACK, sample_en=1: compare b with the current bin_out.
    - b == bin_out: no pulse.
    - b == bin_out+1, modulo 2^WIDTH (all-ones to 0 is a legal step): step_up=1.
    - Any other value (including -1 and multi-step jumps): step_err=1.
    - bin_out<=b in all three cases (resynchronise to the new value).
  - TRACK, sample_en=0: hold bin_out. Pulses return to 0.
- Pulses:
  - step_up and step_err are registered and high for exactly the one cycle after the sampling edge.
  - They are mutually exclusive.
- err_count:
  - Increments on each step_err event.
  - Saturates at 2^ERR_W-1 and does not wrap.
  - clr_err=1 sets it to 0. If clr_err coincides with an error, clear wins and the result is 0.
  - The step_err pulse is still emitted when clr_err coincides.
- Latency (with sync enabled):
  - A gray_in value stable before edge k reaches the sync output after edge k+1.
  - A sample at edge k+2 shows it on bin_out after edge k+2.
- Reset mid-operation: outputs clear immediately (asynchronously) and the FSM returns to IDLE. The first sample after reset never flags.
- There is no back-pressure; each sample_en edge is processed independently, including back-to-back samples.

Optional Feature:
- Macro: GRAY_DEC_SYNC_EN.
- Defined: two-flop synchroniser present, latency as above; the block is safe for asynchronous gray_in.
- Undefined: gray_in feeds the decoder directly. A value stable before edge k is sampled at edge k, saving 2 cycles. Only legal when the source shares clk.
- All other behaviour is identical.
- The test plan is written with the macro defined; without it, drop the 2-cycle offset.

Test Plan:
- Reset, then one sample: rst pulse with gray_in=3'b110 held, sample_en high from cycle 3 -> all outputs 0 during reset; bin_out=3'b100 and bin_valid=1 after the first sample; no step pulses.
- Full count with wrap: gray_in stepped 000,001,011,010,110,111,101,100,000, changed 3 cycles apart, sample_en every cycle -> bin_out goes 0..7,0; 8 step_up pulses; 0 step_err; err_count=0.
- Hold: gray_in constant 3'b011 for 10 sampled cycles -> bin_out=2; no pulses.
- Illegal jumps, back-to-back: from bin 0, gray_in=3'b011 (bin 2), then 3'b001 (bin 1, a -1 step) -> two step_err pulses, err_count=2, bin_out=1.
- Saturation and clear: force 300 illegal steps (alternate gray 000/011) -> err_count stops at 255. Assert clr_err together with an error -> err_count=0, step_err still pulses.
- Reset mid-run: assert rst asynchronously while err_count=5 and in TRACK -> immediate zero outputs; the next first sample does not flag, even if non-adjacent to the pre-reset value.
